// File: rtl/tt_um_count_checker.sv
// Receive-side checker for an 8-bit incrementing count stream: locks onto the
// stream, counts sequence errors while locked and reports status on uio_out.
module tt_um_count_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned RUN_W = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   last_sample, last_sample_n;
    logic [RUN_W-1:0]   good_run, good_run_n;
    logic [RUN_W-1:0]   bad_run, bad_run_n;
    logic [CNT_W-1:0]   err_count, err_count_n;
    logic               sat, sat_n;
    logic               err_pulse_n;
    logic               err_hit;

    logic               valid, clr_err, disp_sel, match;
    logic [RUN_W-1:0]   good_inc, bad_inc;

    assign valid    = uio_in[0];
    assign clr_err  = uio_in[1];
    assign disp_sel = uio_in[2];
    assign match    = (ui_in == CNT_W'(last_sample + 8'd1));
    assign good_inc = RUN_W'(good_run + 4'd1);
    assign bad_inc  = RUN_W'(bad_run + 4'd1);

    assign uio_oe = 8'hF0;

    // Power-good and the upper bidir inputs carry no function here.
    logic unused;
    assign unused = &{1'b0, ena, uio_in[7:3]};

    // Next-state: sequencing, run counters and error accounting.
    always_comb begin
        state_n       = state;
        last_sample_n = last_sample;
        good_run_n    = good_run;
        bad_run_n     = bad_run;
        err_count_n   = err_count;
        sat_n         = sat;
        err_pulse_n   = 1'b0;
        err_hit       = 1'b0;

        if (valid) begin
            last_sample_n = ui_in;
            case (state)
                IDLE: begin
                    state_n    = HUNT;
                    good_run_n = '0;
                end
                HUNT: begin
                    if (match) begin
                        good_run_n = good_inc;
                        if (good_inc == RUN_W'(LOCK_COUNT)) begin
                            state_n   = LOCKED;
                            bad_run_n = '0;
                        end
                    end else begin
                        good_run_n = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        bad_run_n = '0;
                    end else begin
                        err_hit   = 1'b1;
                        bad_run_n = bad_inc;
                        if (bad_inc == RUN_W'(LOSS_COUNT)) begin
                            state_n    = HUNT;
                            good_run_n = '0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        err_pulse_n = err_hit;
        // A clear in the same cycle as an error wins over the increment.
        if (clr_err) begin
            err_count_n = '0;
            sat_n       = 1'b0;
        end else if (err_hit) begin
            if (err_count != 8'hFF) begin
                err_count_n = CNT_W'(err_count + 8'd1);
            end
            sat_n = sat | (err_count_n == 8'hFF);
        end
    end

    // All state and outputs registered; outputs built from next-state values
    // so status reflects a sample one clock after its edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_sample <= '0;
            good_run    <= '0;
            bad_run     <= '0;
            err_count   <= '0;
            sat         <= 1'b0;
            uo_out      <= '0;
            uio_out     <= '0;
        end else begin
            state       <= state_n;
            last_sample <= last_sample_n;
            good_run    <= good_run_n;
            bad_run     <= bad_run_n;
            err_count   <= err_count_n;
            sat         <= sat_n;
            uo_out      <= disp_sel ? err_count_n : last_sample_n;
            uio_out     <= {state_n == HUNT, sat_n, err_pulse_n,
                            state_n == LOCKED, 4'b0000};
        end
    end

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Directed bench for tt_um_count_checker: vector table plus a saturation
// sequence, all expectations hand-computed.
module tb_tt_um_count_checker;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [7:0] HU = 8'h80;
    localparam logic [7:0] SA = 8'h40;
    localparam logic [7:0] EP = 8'h20;
    localparam logic [7:0] LK = 8'h10;

    tt_um_count_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic       clr;
        logic       disp;
        logic [7:0] data;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic c, input logic d,
                       input logic [7:0] data, input logic [7:0] eu, input logic [7:0] eio);
        vec_t t;
        t.rst = r; t.valid = v; t.clr = c; t.disp = d;
        t.data = data; t.exp_uo = eu; t.exp_uio = eio;
        vecs.push_back(t);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic c, input logic d,
                        input logic [7:0] data);
        @(negedge clk);
        rst_n  = ~r;
        ui_in  = data;
        uio_in = {5'b0, d, c, v};
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] eu, input logic [7:0] eio);
        n_checks++;
        if (uo_out === eu && uio_out === eio && uio_oe === 8'hF0) begin
            n_pass++;
        end else begin
            $display("FAIL %s: uo_out=%02h uio_out=%02h uio_oe=%02h, expected uo_out=%02h uio_out=%02h uio_oe=F0",
                     name, uo_out, uio_out, uio_oe, eu, eio);
        end
    endtask

    initial begin
        logic [7:0] last;
        logic [7:0] mis;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        //   rst v  c  d  data  uo    uio
        add(1, 0, 0, 0, 8'd0,  8'd0,  8'h00);      // reset
        add(0, 1, 0, 0, 8'd10, 8'd10, HU);         // IDLE -> HUNT
        add(0, 1, 0, 0, 8'd11, 8'd11, HU);
        add(0, 1, 0, 0, 8'd12, 8'd12, HU);
        add(0, 1, 0, 0, 8'd13, 8'd13, HU);
        add(0, 1, 0, 0, 8'd14, 8'd14, LK);         // lock after 4 matches
        add(0, 1, 0, 0, 8'd50, 8'd50, LK | EP);    // single error
        add(0, 1, 0, 0, 8'd51, 8'd51, LK);
        add(0, 1, 0, 0, 8'd52, 8'd52, LK);
        add(0, 0, 0, 1, 8'd99, 8'd1,  LK);         // show err_count=1
        add(0, 0, 1, 1, 8'd99, 8'd0,  LK);         // clear
        add(0, 1, 0, 1, 8'd7,  8'd1,  LK | EP);    // 7,7,7 -> loss
        add(0, 1, 0, 1, 8'd7,  8'd2,  LK | EP);
        add(0, 1, 0, 1, 8'd7,  8'd3,  HU | EP);
        add(0, 1, 0, 0, 8'd8,  8'd8,  HU);         // relock
        add(0, 1, 0, 0, 8'd9,  8'd9,  HU);
        add(0, 1, 0, 0, 8'd10, 8'd10, HU);
        add(0, 1, 0, 0, 8'd11, 8'd11, LK);
        add(0, 1, 0, 0, 8'd12, 8'd12, LK);
        add(0, 0, 0, 0, 8'd77, 8'd12, LK);         // valid gaps
        add(0, 0, 0, 0, 8'd78, 8'd12, LK);
        add(0, 0, 0, 0, 8'd79, 8'd12, LK);
        add(0, 1, 0, 1, 8'd13, 8'd3,  LK);         // no error across gap
        add(0, 1, 1, 1, 8'd40, 8'd0,  LK | EP);    // clear beats error
        add(0, 1, 0, 1, 8'd41, 8'd0,  LK);
        add(1, 1, 0, 0, 8'd42, 8'd0,  8'h00);      // mid-stream reset
        add(0, 1, 0, 0, 8'd5,  8'd5,  HU);
        add(0, 1, 0, 0, 8'd250, 8'd250, HU);       // wrap sequence
        add(0, 1, 0, 0, 8'd251, 8'd251, HU);
        add(0, 1, 0, 0, 8'd252, 8'd252, HU);
        add(0, 1, 0, 0, 8'd253, 8'd253, HU);
        add(0, 1, 0, 0, 8'd254, 8'd254, LK);
        add(0, 1, 0, 0, 8'd255, 8'd255, LK);
        add(0, 1, 0, 0, 8'd0,   8'd0,   LK);       // 255 -> 0 is a match
        add(0, 1, 0, 1, 8'd1,   8'd0,   LK);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].clr, vecs[i].disp, vecs[i].data);
            check($sformatf("vec%0d", i), vecs[i].exp_uo, vecs[i].exp_uio);
        end

        // Saturation: one error then a match, repeated while staying locked.
        last = 8'd1;
        for (int i = 0; i < 260; i++) begin
            mis = 8'(last + 8'd5);
            step(0, 1, 0, 1, mis);
            if (i == 253) check("err_254_nosat", 8'd254, LK | EP);
            if (i == 254) check("err_255_sat", 8'd255, LK | EP | SA);
            if (i == 259) check("err_sat_hold", 8'd255, LK | EP | SA);
            last = 8'(mis + 8'd1);
            step(0, 1, 0, 1, last);
        end
        check("sat_after_match", 8'd255, LK | SA);
        step(0, 0, 1, 1, 8'd0);
        check("clr_sat", 8'd0, LK);
        step(0, 0, 0, 0, 8'd0);
        check("disp_last", last, LK);
        step(1, 1, 1, 1, 8'd3);
        check("reset_final", 8'd0, 8'h00);
        step(0, 0, 0, 0, 8'd3);
        check("idle_after_reset", 8'd0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
